// File: rtl/gyro_pkg.sv
// Shared constants for the gyro SPI slave: register map, reset values, FSM encoding.
package gyro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [5:0] ADDR_WHO_AM_I  = 6'h0F;
  localparam logic [5:0] ADDR_CTRL_REG1 = 6'h20;
  localparam logic [5:0] ADDR_CTRL_REG2 = 6'h21;
  localparam logic [5:0] ADDR_CTRL_REG3 = 6'h22;
  localparam logic [5:0] ADDR_CTRL_REG4 = 6'h23;
  localparam logic [5:0] ADDR_CTRL_REG5 = 6'h24;
  localparam logic [5:0] ADDR_OUT_X_L   = 6'h28;
  localparam logic [5:0] ADDR_OUT_X_H   = 6'h29;
  localparam logic [5:0] ADDR_OUT_Y_L   = 6'h2A;
  localparam logic [5:0] ADDR_OUT_Y_H   = 6'h2B;
  localparam logic [5:0] ADDR_OUT_Z_L   = 6'h2C;
  localparam logic [5:0] ADDR_OUT_Z_H   = 6'h2D;

  localparam logic [7:0] WHO_AM_I_VAL = 8'hD3;

  // Index 0 is CTRL_REG1.
  localparam logic [4:0][7:0] CTRL_RST = {8'h00, 8'h00, 8'h00, 8'h00, 8'h07};
  localparam logic [7:0]      OUT_RST  = 8'h00;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizers for the SPI pins plus sclk / chip_select edge detection in clk.
module spi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_sclk,
  input  logic i_cs,
  input  logic i_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_cs_level,
  output logic o_cs_rise,
  output logic o_cs_fall,
  output logic o_mosi
);

  logic [2:0] r_sclk_sr;
  logic [2:0] r_cs_sr;
  logic [1:0] r_mosi_sr;

  // cs chain resets low so a frame still active at reset release never looks like a new falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_sr <= 3'b111;
      r_cs_sr   <= 3'b000;
      r_mosi_sr <= 2'b00;
    end else begin
      r_sclk_sr <= {r_sclk_sr[1:0], i_sclk};
      r_cs_sr   <= {r_cs_sr[1:0], i_cs};
      r_mosi_sr <= {r_mosi_sr[0], i_mosi};
    end
  end

  assign o_sclk_rise = r_sclk_sr[1] & ~r_sclk_sr[2];
  assign o_sclk_fall = ~r_sclk_sr[1] & r_sclk_sr[2];
  assign o_cs_level  = r_cs_sr[1];
  assign o_cs_rise   = r_cs_sr[1] & ~r_cs_sr[2];
  assign o_cs_fall   = ~r_cs_sr[1] & r_cs_sr[2];
  assign o_mosi      = r_mosi_sr[1];

endmodule

// File: rtl/gyro_spi_slave.sv
// SPI mode-3 register slave for a gyro: command/data FSM, register map and sample capture.
// Define GYRO_SPI_SLAVE_AUTOINC_EN to honour the MS (auto-increment) command bit.
module gyro_spi_slave
  import gyro_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        chip_select,
  input  logic        mosi,
  output logic        miso,
  input  logic        sample_valid,
  input  logic [15:0] x_axis,
  input  logic [15:0] y_axis,
  input  logic [15:0] z_axis,
  output logic        interrupt
);

  logic w_sclk_rise, w_sclk_fall, w_cs, w_cs_rise, w_cs_fall, w_mosi;

  spi_edge_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_sclk     (sclk),
    .i_cs       (chip_select),
    .i_mosi     (mosi),
    .o_sclk_rise(w_sclk_rise),
    .o_sclk_fall(w_sclk_fall),
    .o_cs_level (w_cs),
    .o_cs_rise  (w_cs_rise),
    .o_cs_fall  (w_cs_fall),
    .o_mosi     (w_mosi)
  );

  state_t            r_state, w_state_next;
  logic [2:0]        r_bit_cnt;
  logic [6:0]        r_shift_in;
  logic [7:0]        r_shift_out;
  logic              r_rw;
  logic [5:0]        r_addr;
  logic              r_miso;
  logic [4:0][7:0]   r_ctrl;
  logic [5:0][7:0]   r_out;
  logic [47:0]       r_pend_data;
  logic              r_pend_v;
  logic              r_irq;

  logic [7:0] w_rx_byte;
  logic       w_cmd_done, w_byte_done;
  logic [5:0] w_addr_next;
  logic       w_wr_en, w_rd_clr, w_load_direct, w_load_pend;

  function automatic logic [7:0] reg_read(input logic [5:0] a,
                                          input logic [4:0][7:0] ctrl,
                                          input logic [5:0][7:0] outr);
    case (a)
      ADDR_WHO_AM_I:  return WHO_AM_I_VAL;
      ADDR_CTRL_REG1: return ctrl[0];
      ADDR_CTRL_REG2: return ctrl[1];
      ADDR_CTRL_REG3: return ctrl[2];
      ADDR_CTRL_REG4: return ctrl[3];
      ADDR_CTRL_REG5: return ctrl[4];
      ADDR_OUT_X_L:   return outr[0];
      ADDR_OUT_X_H:   return outr[1];
      ADDR_OUT_Y_L:   return outr[2];
      ADDR_OUT_Y_H:   return outr[3];
      ADDR_OUT_Z_L:   return outr[4];
      ADDR_OUT_Z_H:   return outr[5];
      default:        return 8'h00;
    endcase
  endfunction

  assign w_rx_byte   = {r_shift_in, w_mosi};
  assign w_cmd_done  = !w_cs_rise && (r_state == ST_CMD)  && w_sclk_rise && (r_bit_cnt == 3'd7);
  assign w_byte_done = !w_cs_rise && (r_state == ST_DATA) && w_sclk_rise && (r_bit_cnt == 3'd7);

`ifdef GYRO_SPI_SLAVE_AUTOINC_EN
  logic r_ms;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_ms <= 1'b0;
    else if (w_cmd_done) r_ms <= w_rx_byte[6];
  end
  assign w_addr_next = r_ms ? r_addr + 6'd1 : r_addr;
`else
  assign w_addr_next = r_addr;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_cs_rise) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_cs_fall) w_state_next = ST_CMD;
        ST_CMD:  if (w_cmd_done) w_state_next = ST_DATA;
        ST_DATA: w_state_next = ST_DATA;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Shift path: read data is preloaded at each byte boundary so bit7 is ready for the next falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt   <= 3'd0;
      r_shift_in  <= 7'd0;
      r_shift_out <= 8'd0;
      r_rw        <= 1'b0;
      r_addr      <= 6'd0;
      r_miso      <= 1'b0;
    end else if (w_cs_rise || r_state == ST_IDLE) begin
      r_bit_cnt <= 3'd0;
      r_miso    <= 1'b0;
    end else if (r_state == ST_CMD) begin
      r_miso <= 1'b0;
      if (w_sclk_rise) begin
        r_shift_in <= w_rx_byte[6:0];
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end
      if (w_cmd_done) begin
        r_rw        <= w_rx_byte[7];
        r_addr      <= w_rx_byte[5:0];
        r_shift_out <= reg_read(w_rx_byte[5:0], r_ctrl, r_out);
      end
    end else begin
      if (w_sclk_fall) begin
        r_miso      <= r_rw & r_shift_out[7];
        r_shift_out <= {r_shift_out[6:0], 1'b0};
      end
      if (w_sclk_rise) begin
        r_shift_in <= w_rx_byte[6:0];
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end
      if (w_byte_done) begin
        r_addr      <= w_addr_next;
        r_shift_out <= reg_read(w_addr_next, r_ctrl, r_out);
      end
    end
  end

  assign w_wr_en       = w_byte_done && !r_rw;
  assign w_rd_clr      = w_byte_done && r_rw && (r_addr == ADDR_OUT_Z_H);
  assign w_load_direct = sample_valid && w_cs;
  assign w_load_pend   = w_cs_rise && r_pend_v && !w_load_direct;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl      <= CTRL_RST;
      r_out       <= {6{OUT_RST}};
      r_pend_data <= 48'd0;
      r_pend_v    <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_wr_en) begin
        case (r_addr)
          ADDR_CTRL_REG1: r_ctrl[0] <= w_rx_byte;
          ADDR_CTRL_REG2: r_ctrl[1] <= w_rx_byte;
          ADDR_CTRL_REG3: r_ctrl[2] <= w_rx_byte;
          ADDR_CTRL_REG4: r_ctrl[3] <= w_rx_byte;
          ADDR_CTRL_REG5: r_ctrl[4] <= w_rx_byte;
          default: ;
        endcase
      end
      if (sample_valid && !w_cs) begin
        r_pend_data <= {z_axis, y_axis, x_axis};
        r_pend_v    <= 1'b1;
      end else if (w_cs_rise) begin
        r_pend_v <= 1'b0;
      end
      if (w_load_direct)    r_out <= {z_axis, y_axis, x_axis};
      else if (w_load_pend) r_out <= r_pend_data;
      // Set has priority over the read-completion clear.
      if (w_load_direct || w_load_pend) r_irq <= 1'b1;
      else if (w_rd_clr)                r_irq <= 1'b0;
    end
  end

  assign miso      = r_miso;
  assign interrupt = r_irq;

endmodule

// File: doc/gyro_spi_slave.md
GYRO_SPI_SLAVE -- requirements
Module: gyro_spi_slave

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic in this single domain.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port sclk, input, 1, SPI clock from the master; mode 3 (CPOL=1, CPHA=1).
REQ-004 SHALL have port chip_select, input, 1, active-low frame select.
REQ-005 SHALL have port mosi, input, 1, master-to-slave data, MSB first.
REQ-006 SHALL have port miso, output, 1, slave-to-master data, MSB first.
REQ-007 SHALL have ports sample_valid (input, 1) and x_axis, y_axis, z_axis (input, 16 each), which present a new gyro sample, one-cycle strobe.
REQ-008 SHALL have port interrupt, output, 1, data-ready flag, active-high.

Function
REQ-009 SHALL pass sclk, chip_select and mosi through 2-FF synchronizers and detect sclk edges in clk; clk SHALL be at least 8x the sclk frequency.
REQ-010 SHALL implement states IDLE, CMD and DATA. IDLE->CMD on chip_select falling. CMD->DATA after 8 rising sclk edges. Any state->IDLE on chip_select rising.
REQ-011 Command byte: bit7 = read (1) or write (0), bit6 = MS (auto-increment), bits5:0 = address.
REQ-012 SHALL sample mosi on each rising sclk edge.
REQ-013 SHALL drive miso on each falling sclk edge; bit7 of a read byte SHALL be driven on the falling edge after the 8th command bit.
REQ-014 SHALL drive miso to 0 while chip_select is high and during CMD.
REQ-015 Register map: 0x0F WHO_AM_I = 0xD3 (RO); 0x20-0x24 CTRL_REG1-5 (RW, reset 0x07, 0x00, 0x00, 0x00, 0x00); 0x28-0x2D OUT_X_L, OUT_X_H, OUT_Y_L, OUT_Y_H, OUT_Z_L, OUT_Z_H (RO, reset 0x00).
REQ-016 Reads of unmapped addresses SHALL return 0x00; writes to RO or unmapped addresses SHALL be ignored.
REQ-017 A write byte SHALL commit on its 8th rising sclk edge.
REQ-018 A partial byte at chip_select rising SHALL be discarded, with no commit and no address change.
REQ-019 Read data SHALL be loaded into the shift register at the byte boundary from the current address.
REQ-020 After each complete data byte, the address SHALL increment when MS=1 (subject to REQ-028) and hold otherwise; 0x3F SHALL wrap to 0x00.
REQ-021 Samples are 16-bit two's-complement and SHALL be split LSB to _L and MSB to _H.
REQ-022 sample_valid with chip_select high SHALL update all OUT registers in the next cycle.
REQ-023 sample_valid with chip_select low SHALL be held in a one-deep pending buffer and applied on the cycle after chip_select rising; a newer sample SHALL overwrite the pending one.
REQ-024 interrupt SHALL set when OUT registers update and clear when a full read byte from 0x2D completes; a simultaneous set and clear SHALL leave interrupt set.

Reset
REQ-025 While rst is low, the block SHALL be in state IDLE, miso = 0, interrupt = 0, pending buffer empty, bit and byte counters = 0, and all registers at their REQ-015 reset values.
REQ-026 A reset asserted mid-frame SHALL abort the frame; after release, the block SHALL wait for the next chip_select falling edge.

Configuration
REQ-027 Macro GYRO_SPI_SLAVE_AUTOINC_EN SHALL control auto-increment.
REQ-028 With GYRO_SPI_SLAVE_AUTOINC_EN defined, MS SHALL behave per REQ-020; without it, MS SHALL be ignored and the address SHALL always hold.

Structure
REQ-029 Register addresses, reset values, the WHO_AM_I constant and the state encoding SHALL live in the shared package gyro_pkg.
REQ-030 The synchronizer and edge detector SHALL be a sub-module named spi_edge_sync.

Verification
REQ-031 Read WHO_AM_I: command 0x8F then one dummy byte -> miso returns 0xD3.
REQ-032 Write then read back: command 0x20 + data 0x0F, then 0xA0 + dummy -> returns 0x0F; a write of 0x55 to 0x0F -> WHO_AM_I still reads 0xD3.
REQ-033 Burst read: sample x=0x1234, y=0xFFFE, z=0x8000, then command 0xE8 + 6 dummy bytes -> returns 34 12 FE FF 00 80, and interrupt drops after the 6th byte.
REQ-034 Burst without MS: command 0xA8 + 3 dummy bytes -> returns 34 34 34; with the macro undefined, 0xE8 + 2 dummy bytes -> returns 34 34.
REQ-035 Pending sample: sample_valid mid-frame with x=0x0001 -> the in-frame read returns the old value, and after chip_select rising OUT_X_L = 0x01 with interrupt = 1.
REQ-036 Abort: chip_select raised after 4 bits of a write data byte to 0x21 -> CTRL_REG2 remains 0x00; rst pulled low mid-read -> miso = 0 and the next frame decodes correctly.
